// File: rtl/fomo_pkg.sv
// Shared types and default constants for the FOMO frame sequencer.
package fomo_pkg;

  typedef enum logic [1:0] {
    SCROLL_FWD = 2'b00,
    ZOOM_PP    = 2'b01,
    HOLD       = 2'b10,
    SCROLL_REV = 2'b11
  } fomo_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_STEP,
    ST_APPLY
  } fomo_state_t;

  localparam int STEP_X_BASE = 704;
  localparam int STEP_Y_BASE = 720;

endpackage

// File: rtl/fomo_pingpong.sv
// 8-bit saturating bounce counter: climbs to 255, then falls to 0, then repeats.
module fomo_pingpong (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] step,
  input  logic       en,
  output logic [7:0] value,
  output logic       dir
);
  import fomo_pkg::*;

  // Returns {next_dir, next_value}; dir 0 counts up, 1 counts down.
  function automatic logic [8:0] bounce(input logic [7:0] v, input logic d,
                                        input logic [3:0] s);
    logic [8:0] sum;
    sum = {1'b0, v} + {5'b0, s};
    if (!d) begin
      if (sum >= 9'd255) return {1'b1, 8'd255};
      else               return {1'b0, sum[7:0]};
    end else begin
      if (v <= {4'b0, s}) return {1'b0, 8'd0};
      else                return {1'b1, v - {4'b0, s}};
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 8'd0;
      dir   <= 1'b0;
    end else if (en) begin
      {dir, value} <= bounce(value, dir, step);
    end
  end

endmodule

// File: rtl/fomo_frame_sequencer.sv
// Per-frame animation sequencer: on each vsync rise, advances frame/scroll/zoom
// state, derives texture steps, and strobes apply three cycles after the rise.
module fomo_frame_sequencer #(
  parameter int STEP_X_BASE = fomo_pkg::STEP_X_BASE,
  parameter int STEP_Y_BASE = fomo_pkg::STEP_Y_BASE,
  parameter int CNT_W       = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync,
  input  logic [1:0]       cfg_mode,
  input  logic [2:0]       cfg_speed,
  input  logic             cfg_pause,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] scroll,
  output logic [7:0]       zoom,
  output logic [10:0]      step_x,
  output logic [10:0]      step_y,
  output logic             apply,
  output logic             busy
);
  import fomo_pkg::*;

  fomo_state_t state;
  fomo_mode_t  mode_sh;
  logic [3:0]  step_sh;
  logic        pause_sh;
  logic        vs_q;
  logic        rise;
  logic        zoom_en;
  logic        zoom_dir;

  assign rise    = vsync & ~vs_q;
  assign zoom_en = (state == ST_CALC) && !pause_sh && (mode_sh == ZOOM_PP);

  fomo_pingpong u_zoom (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (step_sh),
    .en    (zoom_en),
    .value (zoom),
    .dir   (zoom_dir)
  );

  // vs_q resets high so a vsync already high at reset release is not a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vs_q <= 1'b1;
    else        vs_q <= vsync;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      mode_sh     <= SCROLL_FWD;
      step_sh     <= 4'd1;
      pause_sh    <= 1'b0;
      frame_count <= '0;
      scroll      <= '0;
      step_x      <= 11'(STEP_X_BASE);
      step_y      <= 11'(STEP_Y_BASE);
      apply       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise) begin
            mode_sh  <= fomo_mode_t'(cfg_mode);
            step_sh  <= {1'b0, cfg_speed} + 4'd1;
            pause_sh <= cfg_pause;
            busy     <= 1'b1;
            state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          frame_count <= frame_count + CNT_W'(1);
          if (!pause_sh) begin
            if (mode_sh == SCROLL_FWD)      scroll <= scroll + CNT_W'(step_sh);
            else if (mode_sh == SCROLL_REV) scroll <= scroll - CNT_W'(step_sh);
          end
          state <= ST_STEP;
        end
        ST_STEP: begin
          // zoom already holds the value written on the previous edge.
          step_x <= 11'(STEP_X_BASE) + {5'b0, zoom[7:2]};
          step_y <= 11'(STEP_Y_BASE) + {3'b0, zoom};
          apply  <= 1'b1;
          state  <= ST_APPLY;
        end
        ST_APPLY: begin
          apply <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fomo_frame_sequencer.sv
// Directed and randomized bench for fomo_frame_sequencer with a frame-level reference model.
module tb_fomo_frame_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b1;
  logic [1:0] cfg_mode = 2'd0;
  logic [2:0] cfg_speed = 3'd0;
  logic       cfg_pause = 1'b0;
  logic [9:0] frame_count, scroll;
  logic [7:0] zoom;
  logic [10:0] step_x, step_y;
  logic       apply, busy;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_fc, m_scroll, m_zoom;
  bit m_down;

  always #5 clk = ~clk;

  fomo_frame_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vsync       (vsync),
    .cfg_mode    (cfg_mode),
    .cfg_speed   (cfg_speed),
    .cfg_pause   (cfg_pause),
    .frame_count (frame_count),
    .scroll      (scroll),
    .zoom        (zoom),
    .step_x      (step_x),
    .step_y      (step_y),
    .apply       (apply),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fc = 0; m_scroll = 0; m_zoom = 0; m_down = 0;
  endtask

  task automatic model_frame(input int mode, input int speed, input bit pause);
    int s;
    s = speed + 1;
    m_fc = (m_fc + 1) % 1024;
    if (!pause) begin
      case (mode)
        0: m_scroll = (m_scroll + s) % 1024;
        3: m_scroll = (m_scroll - s + 1024) % 1024;
        1: begin
          if (!m_down) begin
            if (m_zoom + s >= 255) begin m_zoom = 255; m_down = 1; end
            else m_zoom = m_zoom + s;
          end else begin
            if (m_zoom <= s) begin m_zoom = 0; m_down = 0; end
            else m_zoom = m_zoom - s;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".frame_count"}, frame_count, m_fc);
    check({tag, ".scroll"}, scroll, m_scroll);
    check({tag, ".zoom"}, zoom, m_zoom);
    check({tag, ".step_x"}, step_x, 704 + m_zoom / 4);
    check({tag, ".step_y"}, step_y, 720 + m_zoom);
  endtask

  task automatic do_reset(input logic vs_level);
    @(negedge clk);
    rst_n = 1'b0;
    vsync = vs_level;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  // One frame: vsync rises, config is scrambled after E0 to confirm it was latched.
  task automatic frame(input int mode, input int speed, input bit pause);
    int first;
    int hits;
    @(negedge clk);
    cfg_mode  = 2'(mode);
    cfg_speed = 3'(speed);
    cfg_pause = pause;
    vsync     = 1'b1;
    model_frame(mode, speed, pause);
    first = 0;
    hits  = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (apply) begin
        hits++;
        if (first == 0) first = k;
      end
      if (k == 1) begin
        check("busy_after_rise", busy, 1);
        cfg_mode  = 2'($urandom_range(3));
        cfg_speed = 3'($urandom_range(7));
        cfg_pause = 1'($urandom_range(1));
      end
      if (k == 2) vsync = 1'b0;
      if (k == 4) check("busy_after_apply", busy, 0);
    end
    check("apply_latency", first, 3);
    check("apply_pulses", hits, 1);
  endtask

  initial begin
    int seen;
    // Reset release with vsync held high must not produce a frame.
    rst_n = 1'b0;
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (apply || busy) seen++;
    end
    check("reset_no_apply", seen, 0);
    check_outputs("reset");
    vsync = 1'b0;
    repeat (2) @(negedge clk);

    // Forward scroll, speed 3, five frames.
    for (int f = 0; f < 5; f++) frame(0, 3, 0);
    check("fwd5.scroll_abs", scroll, 20);
    check("fwd5.frame_abs", frame_count, 5);
    check_outputs("fwd5");

    // Reverse scroll wraps below zero.
    do_reset(1'b0);
    frame(3, 0, 0);
    check("rev_wrap.scroll_abs", scroll, 1023);
    check_outputs("rev_wrap");

    // Zoom ping-pong, speed 7: saturate high then low.
    do_reset(1'b0);
    for (int f = 0; f < 32; f++) frame(1, 7, 0);
    check("zoom_top.zoom_abs", zoom, 255);
    check("zoom_top.step_x_abs", step_x, 767);
    check("zoom_top.step_y_abs", step_y, 975);
    check_outputs("zoom_top");
    for (int f = 0; f < 32; f++) frame(1, 7, 0);
    check("zoom_bot.zoom_abs", zoom, 0);
    check_outputs("zoom_bot");
    frame(1, 7, 0);
    check("zoom_rebound.zoom_abs", zoom, 8);

    // Pause freezes scroll but frames still count and apply still pulses.
    do_reset(1'b0);
    frame(0, 2, 0);
    for (int f = 0; f < 4; f++) frame(0, 5, 1);
    check("pause.scroll_abs", scroll, 3);
    check("pause.frame_abs", frame_count, 5);
    check_outputs("pause");

    // Randomized frames against the model.
    for (int f = 0; f < 40; f++) begin
      frame($urandom_range(3), $urandom_range(7), 1'($urandom_range(3) == 0));
      check_outputs("random");
    end

    // Reset asserted while in STEP discards the update.
    @(negedge clk);
    cfg_mode = 2'd0; cfg_speed = 3'd4; cfg_pause = 1'b0;
    vsync = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst.apply", apply, 0);
    check("midrst.busy", busy, 0);
    check_outputs("midrst");
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (apply) seen++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (apply || busy) seen++;
    end
    check("midrst.no_apply", seen, 0);
    check_outputs("midrst_after");
    vsync = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
